// File: rtl/stack_isa_pkg.sv
// Shared stack-processor ISA definitions: 16-bit instruction word made of a
// 3-bit opcode field [15:13] and a 13-bit operand field [12:0].
// Imported by both the 3b/13b merger and the splitter.
package stack_isa_pkg;

    localparam int WORD_W = 16;
    localparam int OP_W   = 3;
    localparam int IMM_W  = 13;
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;

    typedef logic [OP_W-1:0] op_t;

endpackage

// File: rtl/split_fifo.sv
// Generic DEPTH x WIDTH circular-buffer FIFO with valid/ready on both sides
// and a synchronous flush. in_ready/out_valid come from registered occupancy
// only, so there is no combinational path from inputs to handshake outputs.
// The head entry is read combinationally; storage resets to zero.
module split_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;

    // Full check uses registered occupancy only; a same-cycle pop does not free a slot.
    assign in_ready  = (occ < OCC_FULL);
    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer/occupancy update; flush wins over push and pop, pointers wrap at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/splitter_16b_3b13b.sv
// Buffered 3b/13b instruction-word splitter. Words are queued in split_fifo;
// the head word is split into opcode, operand and a 16-bit extended operand.
// split_cnt counts popped words since reset or flush (wraps).
// Build option: define SPLIT_SIGN_EXT_EN to sign-extend out_imm_ext;
// otherwise it is zero-extended.
module splitter_16b_3b13b
    import stack_isa_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [12:0]      out_imm,
    output logic [15:0]      out_imm_ext,
    output logic [CNT_W-1:0] split_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WORD_W-1:0] head;
    logic              pop;
    op_t               head_op;

    split_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign pop     = out_valid & out_ready;
    assign head_op = head[OP_MSB:OP_LSB];
    assign out_op  = head_op;
    assign out_imm = head[IMM_W-1:0];

`ifdef SPLIT_SIGN_EXT_EN
    assign out_imm_ext = {{(WORD_W-IMM_W){out_imm[IMM_W-1]}}, out_imm};
`else
    assign out_imm_ext = {{(WORD_W-IMM_W){1'b0}}, out_imm};
`endif

    // Popped-word counter; a pop in a flush cycle is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (flush) begin
            split_cnt <= '0;
        end else if (pop) begin
            split_cnt <= split_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_splitter_16b_3b13b.sv
// Self-checking bench for splitter_16b_3b13b: table-driven field split
// vectors plus directed backpressure, streaming, flush and reset sequences.
module tb_splitter_16b_3b13b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [12:0] out_imm;
    logic [15:0] out_imm_ext;
    logic [15:0] split_cnt;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_cnt;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  op;
        logic [12:0] imm;
        logic [15:0] ext_s;
        logic [15:0] ext_z;
    } vec_t;

    vec_t vecs [7];

    splitter_16b_3b13b #(.DEPTH(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_imm     (out_imm),
        .out_imm_ext (out_imm_ext),
        .split_cnt   (split_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_ext(input vec_t v);
`ifdef SPLIT_SIGN_EXT_EN
        return v.ext_s;
`else
        return v.ext_z;
`endif
    endfunction

    logic [15:0] got [$];
    logic [15:0] words [8];
    bit          acc;

    initial begin
        vecs[0] = '{16'hE007, 3'b111, 13'h0007, 16'h0007, 16'h0007};
        vecs[1] = '{16'hB024, 3'b101, 13'h1024, 16'hF024, 16'h1024};
        vecs[2] = '{16'hCA24, 3'b110, 13'h0A24, 16'h0A24, 16'h0A24};
        vecs[3] = '{16'h0001, 3'b000, 13'h0001, 16'h0001, 16'h0001};
        vecs[4] = '{16'h1FFF, 3'b000, 13'h1FFF, 16'hFFFF, 16'h1FFF};
        vecs[5] = '{16'hFFFF, 3'b111, 13'h1FFF, 16'hFFFF, 16'h1FFF};
        vecs[6] = '{16'h1234, 3'b000, 13'h1234, 16'hF234, 16'h1234};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset split_cnt", split_cnt, 0);
        chk("reset out_op", out_op, 0);
        chk("reset out_imm", out_imm, 0);
        chk("reset out_imm_ext", out_imm_ext, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        exp_cnt = 16'd0;

        // Table: push one word, check split fields, pop it, check counter.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_word = vecs[i].word;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d out_op", i), out_op, vecs[i].op);
            chk($sformatf("vec%0d out_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("vec%0d out_imm_ext", i), out_imm_ext, exp_ext(vecs[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_cnt++;
            chk($sformatf("vec%0d split_cnt", i), split_cnt, exp_cnt);
            chk($sformatf("vec%0d empty after pop", i), out_valid, 0);
        end

        // Backpressure: two words fill the FIFO, third is held until space frees.
        in_valid = 1'b1; in_word = 16'hCA24;
        step();
        in_word = 16'h0001;
        step();
        in_word = 16'h1234;
        chk("bp in_ready full", in_ready, 0);
        step();
        chk("bp in_ready held", in_ready, 0);
        chk("bp head op", out_op, 3'b110);
        chk("bp head imm", out_imm, 13'h0A24);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            acc = in_valid & in_ready;
            if (out_valid & out_ready) got.push_back({out_op, out_imm});
            step();
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("bp pop count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp word0", got[0], 16'hCA24);
            chk("bp word1", got[1], 16'h0001);
            chk("bp word2", got[2], 16'h1234);
        end
        exp_cnt = exp_cnt + 16'd3;
        chk("bp split_cnt", split_cnt, exp_cnt);

        // Flush while empty clears the counter.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush split_cnt", split_cnt, 0);

        // Streaming: 8 back-to-back pushes with out_ready held high.
        for (int i = 0; i < 8; i++) words[i] = 16'h2101 * 16'(i + 1);
        got.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_word = words[c];
                chk($sformatf("stream in_ready c%0d", c), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            if (c == 0) chk("stream latency empty", out_valid, 0);
            if (c >= 1 && c <= 8) chk($sformatf("stream out_valid c%0d", c), out_valid, 1);
            if (out_valid & out_ready) got.push_back({out_op, out_imm});
            step();
        end
        out_ready = 1'b0;
        chk("stream pop count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("stream word%0d", i), got[i], words[i]);
        chk("stream split_cnt", split_cnt, 8);

        // Flush collision with push and pop while full.
        in_valid = 1'b1; in_word = 16'h1111;
        step();
        in_word = 16'h2222;
        step();
        chk("fc full in_ready", in_ready, 0);
        chk("fc full out_valid", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_word = 16'h5555; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fc out_valid", out_valid, 0);
        chk("fc in_ready", in_ready, 1);
        chk("fc split_cnt", split_cnt, 0);
        step();
        chk("fc word dropped", out_valid, 0);

        // Reset mid-stream with two words buffered and a nonzero counter.
        in_valid = 1'b1; in_word = 16'h4321;
        step();
        out_ready = 1'b1; in_word = 16'h6789;
        step();
        out_ready = 1'b0; in_word = 16'h7777;
        step();
        in_valid = 1'b0;
        chk("mid pre split_cnt", split_cnt, 1);
        chk("mid pre full", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst split_cnt", split_cnt, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid no stale c%0d", c), out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/splitter_16b_3b13b.md
# splitter_16b_3b13b

Buffered instruction-word splitter for the stack processor's fetch/decode path. It accepts 16-bit instruction words over a valid/ready handshake and holds them in a small FIFO. For the word at the head it presents the 3-bit opcode field, the 13-bit operand field and a 16-bit extended operand. It is the inverse of the 3b/13b merge: every word built from (op, imm) reappears here as exactly that pair.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the popped-word counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered words.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- in_word  in  16  instruction word; [15:13] opcode, [12:0] operand.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes the head this cycle.
- out_op  out  3  in_word[15:13] of the head entry.
- out_imm  out  13  in_word[12:0] of the head entry.
- out_imm_ext  out  16  out_imm extended to 16 bits (see Configuration).
- split_cnt  out  CNT_W  number of words popped since reset or flush.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH), registered occupancy only; it does not look ahead to a same-cycle pop.
- out_valid = (count != 0).
- Storage:
  - Circular buffer with write pointer, read pointer and count of $clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
- push only: write at wr_ptr, wr_ptr++, count++.
- pop only: rd_ptr++, count--, split_cnt++.
- push & pop together:
  - Legal only when 0 < count < DEPTH.
  - Both pointers advance, count is unchanged and split_cnt increments.
- Full (count == DEPTH): in_ready = 0, so no push occurs even if a pop happens that cycle.
- Empty: no bypass. A word pushed while empty is not visible at the output until the next cycle.
- flush:
  - Clears the pointers, count and split_cnt to 0.
  - Has priority over push and pop in the same cycle; that cycle's in_word is discarded and the pop is not counted.
- split_cnt wraps from 2^CNT_W−1 to 0.
- Output fields are a combinational read of the head entry.
  - When out_valid = 0 they hold the last head contents, which are don't-care.
  - The bench checks them only when out_valid = 1.
- Reset may assert mid-transfer; all state clears immediately and buffered words are lost.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, split_cnt = 0.
  - out_op, out_imm and out_imm_ext = 0, because storage resets to 0.
- Latency: word pushed at edge N → out_valid and fields valid after edge N.
- Throughput: one word per cycle sustained when out_ready is held high.
- in_ready and out_valid depend only on registered state, so there are no combinational paths in→out.
- flush at edge N: after edge N, out_valid = 0 and in_ready = 1.

## Configuration
- SPLIT_SIGN_EXT_EN:
  - Defined: out_imm_ext = {{3{out_imm[12]}}, out_imm}, i.e. sign-extended.
  - Undefined: out_imm_ext = {3'b000, out_imm}, i.e. zero-extended.
- No other behaviour changes with this macro.

## Structure
- Shared package `stack_isa_pkg`:
  - WORD_W = 16, OP_W = 3, IMM_W = 13.
  - Opcode field bounds OP_MSB = 15, OP_LSB = 13.
  - Typedef for the opcode.
- The merger and this splitter both import the package.
- Sub-module `split_fifo`:
  - Generic DEPTH × WORD_W FIFO carrying the handshake, pointers, count and flush.
  - The top level adds field extraction, extension and split_cnt.

## Test plan
- Reset mid-stream: assert rst_n = 0 with 2 words buffered → in_ready = 1, out_valid = 0 and split_cnt = 0 immediately; no stale word appears after release.
- Split check: push 16'hE007, then pop → out_op = 3'b111, out_imm = 13'h0007, out_imm_ext = 16'h0007, split_cnt = 1.
- Sign extension: push 16'hB024 → out_op = 3'b101, out_imm = 13'h1024, out_imm_ext = 16'hF024 with SPLIT_SIGN_EXT_EN and 16'h1024 without.
- Backpressure: hold out_ready = 0 and push 16'hCA24, 16'h0001, 16'h1234 →
  - The first two are accepted; in_ready = 0 on the third, which is held.
  - Raise out_ready: outputs appear in order 0xCA24 (op 110, imm 0x0A24), 0x0001, 0x1234, with no loss or duplication.
- Streaming: 8 back-to-back pushes with out_ready = 1 → one pop per cycle after 1-cycle latency, and split_cnt = 8.
- Flush collision: fill to full, then assert flush together with in_valid and out_ready → count = 0, split_cnt = 0, pushed word dropped.
